// File: rtl/reg_file_pkg.sv
// Shared types for the handshaked byte-addressed register file: transfer
// sizes, FSM states and the size-to-byte-count helper.
package reg_file_pkg;

    typedef enum logic [1:0] {
        BYTE  = 2'b00,
        HALF  = 2'b01,
        WORD  = 2'b10,
        DWORD = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    function automatic logic [3:0] size_bytes(size_t s);
        return 4'd1 << s;
    endfunction

endpackage

// File: rtl/reg_file_hs_if.sv
// Request/response bundle between a bus master and the register file.
interface reg_file_hs_if
    import reg_file_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
);
    localparam int AW = $clog2(DEPTH);

    logic              en;
    logic [AW-1:0]     addr;
    size_t             size;
    logic              we;
    logic              re;
    logic [DATA_W-1:0] wd_data;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              done;
    logic              check;

    modport master (
        output en, addr, size, we, re, wd_data,
        input  rd_data, rd_valid, done, check
    );

    modport slave (
        input  en, addr, size, we, re, wd_data,
        output rd_data, rd_valid, done, check
    );

endinterface

// File: rtl/reg_file_mem.sv
// Byte-wide storage with little-endian lane steering; byte i of a transfer
// lives at (addr + i) mod DEPTH, so wrap-around falls out of the address width.
module reg_file_mem
    import reg_file_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  size_t                    size,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = DATA_W / 8;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] lane_addr [NB];
    logic [NB-1:0] lane_en;
    logic [3:0]    nbytes;

    always_comb begin
        // NOTE: every variable gets a default before any condition, so no latch is inferred.
        nbytes  = size_bytes(size);
        rdata   = '0;
        lane_en = '0;
        for (int i = 0; i < NB; i++) begin
            lane_addr[i]     = addr + AW'(i);
            lane_en[i]       = (i < int'(nbytes));
            rdata[8*i +: 8]  = lane_en[i] ? mem[lane_addr[i]] : 8'h00;
        end
    end

    // NOTE: storage is ordinary flops, so it is cleared by reset like any register;
    // all sequential state is updated with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
        end else if (wr_en) begin
            for (int j = 0; j < NB; j++) begin
                if (lane_en[j]) mem[lane_addr[j]] <= wdata[8*j +: 8];
            end
        end
    end

endmodule

// File: rtl/reg_file_hs.sv
// Handshaked register file: IDLE/ACCESS/RESP FSM with wait-state counter,
// request capture, error detection and registered read response.
module reg_file_hs
    import reg_file_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 0,
    parameter int WRAP_EN     = 0
) (
    input logic         clk,
    input logic         rst_n,
    reg_file_hs_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = DATA_W / 8;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;

    logic [AW-1:0]     cap_addr;
    size_t             cap_size;
    logic              cap_we, cap_re;
    logic [DATA_W-1:0] cap_wd;

    logic [AW-1:0]     req_addr;
    size_t             req_size;
    logic              req_we, req_re;
    logic [DATA_W-1:0] req_wd;
    logic [3:0]        req_nbytes;
    logic [DATA_W-1:0] lane_mask;
    logic              req_err;

    logic              accept, enter_resp, commit;
    logic [DATA_W-1:0] mem_rdata, rd_data_q;
    logic              rd_valid_q, check_q;

    assign accept = (state != ACCESS) && bus.en && (bus.we || bus.re);

    // With zero wait states the acceptance edge is also the RESP-entry edge,
    // so the live bus request is used instead of the not-yet-captured copy.
    always_comb begin
        if (state == ACCESS) begin
            req_addr = cap_addr;
            req_size = cap_size;
            req_we   = cap_we;
            req_re   = cap_re;
            req_wd   = cap_wd;
        end else begin
            req_addr = bus.addr;
            req_size = bus.size;
            req_we   = bus.we;
            req_re   = bus.re;
            req_wd   = bus.wd_data;
        end
    end

    assign enter_resp = (state == ACCESS) ? (cnt == 4'd0) : (accept && WAIT_STATES == 0);

    always_comb begin
        req_nbytes = size_bytes(req_size);
        lane_mask  = '0;
        for (int i = 0; i < NB; i++) lane_mask[8*i +: 8] = {8{i < int'(req_nbytes)}};
        req_err = (req_we && req_re)
               || (req_size == DWORD && DATA_W < 64)
               || (WRAP_EN == 0 && (int'(req_addr) + int'(req_nbytes) - 1) >= DEPTH)
               || (req_we && |(req_wd & ~lane_mask));
    end

    assign commit = enter_resp && req_we && !req_err;

    reg_file_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (commit),
        .addr  (req_addr),
        .size  (req_size),
        .wdata (req_wd),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = ACCESS;
                        cnt_nxt   = 4'(WAIT_STATES - 1);
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) state_nxt = RESP;
                else             cnt_nxt   = cnt - 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_addr <= '0;
            cap_size <= BYTE;
            cap_we   <= 1'b0;
            cap_re   <= 1'b0;
            cap_wd   <= '0;
        end else if (accept) begin
            cap_addr <= bus.addr;
            cap_size <= bus.size;
            cap_we   <= bus.we;
            cap_re   <= bus.re;
            cap_wd   <= bus.wd_data;
        end
    end

    // Response flags live exactly for the RESP cycle; rd_data holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            check_q    <= 1'b0;
        end else begin
            rd_valid_q <= enter_resp && req_re;
            check_q    <= enter_resp && req_err;
            if (enter_resp && req_re) rd_data_q <= req_err ? '0 : mem_rdata;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.check    = check_q;
    assign bus.done     = (state != ACCESS);

endmodule

// File: tb/tb_reg_file_hs.sv
// Scoreboard bench over three configurations: 32b/no-wait/no-wrap,
// 32b/3-wait/wrap and 64b/2-wait/no-wrap.
module tb_reg_file_hs;
    import reg_file_pkg::*;

    typedef struct {
        logic        rd;
        logic        chk;
        logic [63:0] data;
        int          due;
        string       name;
    } exp_t;

    logic        clk;
    int          cyc = 0;
    int          vectors = 0;
    int          errors = 0;
    int          acc_w, acc_r, acc_x;

    logic        rst_n_v [3];
    logic        en_v    [3];
    logic [4:0]  addr_v  [3];
    size_t       size_v  [3];
    logic        we_v    [3];
    logic        re_v    [3];
    logic [63:0] wd_v    [3];
    logic        done_v  [3];
    logic        rdv_v   [3];
    logic        chk_v   [3];
    logic [63:0] rd_v    [3];

    exp_t exp_q [3][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int DW = (g == 2) ? 64 : 32;
        localparam int WS = (g == 1) ? 3 : ((g == 2) ? 2 : 0);
        localparam int WR = (g == 1) ? 1 : 0;

        reg_file_hs_if #(.DATA_W(DW), .DEPTH(32)) bus ();

        reg_file_hs #(.DATA_W(DW), .DEPTH(32), .WAIT_STATES(WS), .WRAP_EN(WR)) dut (
            .clk   (clk),
            .rst_n (rst_n_v[g]),
            .bus   (bus)
        );

        assign bus.en      = en_v[g];
        assign bus.addr    = addr_v[g];
        assign bus.size    = size_v[g];
        assign bus.we      = we_v[g];
        assign bus.re      = re_v[g];
        assign bus.wd_data = wd_v[g][DW-1:0];
        assign done_v[g]   = bus.done;
        assign rdv_v[g]    = bus.rd_valid;
        assign chk_v[g]    = bus.check;
        assign rd_v[g]     = 64'(bus.rd_data);
    end

    function automatic int ws_of(input int k);
        return (k == 1) ? 3 : ((k == 2) ? 2 : 0);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int k);
        en_v[k] = 1'b0;
        we_v[k] = 1'b0;
        re_v[k] = 1'b0;
    endtask

    // Presents a request and returns the cycle number of its accepting edge.
    task automatic do_req(input int k, input logic w, input logic r, input size_t s,
                          input logic [4:0] a, input logic [63:0] d, output int acc);
        en_v[k] = 1'b1; we_v[k] = w; re_v[k] = r;
        size_v[k] = s; addr_v[k] = a; wd_v[k] = d;
        acc = -1;
        for (int t = 0; t < 64 && acc < 0; t++) begin
            @(negedge clk);
            if (done_v[k]) acc = cyc + 1;
            @(posedge clk);
            #1;
        end
        if (acc < 0) begin
            vectors++;
            errors++;
            $display("FAIL inst%0d accept timeout: done stayed 0, expected 1", k);
        end
    endtask

    task automatic txn(input int k, input logic w, input logic r, input size_t s,
                       input logic [4:0] a, input logic [63:0] d,
                       input logic exp_rd, input logic exp_chk, input logic [63:0] exp_data,
                       input string name, output int acc);
        exp_t e;
        do_req(k, w, r, s, a, d, acc);
        if (acc >= 0 && (exp_rd || exp_chk)) begin
            e.rd = exp_rd; e.chk = exp_chk; e.data = exp_data;
            e.due = acc + ws_of(k); e.name = name;
            exp_q[k].push_back(e);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rdv_v[k] || chk_v[k]) begin
                if (exp_q[k].size() == 0) begin
                    check($sformatf("inst%0d unexpected pulse", k), {62'd0, rdv_v[k], chk_v[k]}, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q[k].pop_front();
                    check({e.name, " rd_valid"}, 64'(rdv_v[k]), 64'(e.rd));
                    check({e.name, " check"}, 64'(chk_v[k]), 64'(e.chk));
                    if (e.rd) check({e.name, " rd_data"}, rd_v[k], e.data);
                    check({e.name, " latency"}, 64'(cyc), 64'(e.due));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_n_v[k] = 1'b0; idle(k);
            size_v[k] = BYTE; addr_v[k] = '0; wd_v[k] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("inst%0d reset done", k), 64'(done_v[k]), 64'd1);
            check($sformatf("inst%0d reset rd_valid", k), 64'(rdv_v[k]), 64'd0);
            check($sformatf("inst%0d reset check", k), 64'(chk_v[k]), 64'd0);
            check($sformatf("inst%0d reset rd_data", k), rd_v[k], 64'd0);
            rst_n_v[k] = 1'b1;
        end
        @(posedge clk); #1;

        // 32b, no wait states, boundary errors enabled
        txn(0, 1, 0, WORD,  5'd4,  64'hA1B2C3D4, 0, 0, 64'h0,        "i0 wr4",     acc_x);
        txn(0, 0, 1, WORD,  5'd4,  64'h0,        1, 0, 64'hA1B2C3D4, "i0 rd4",     acc_x);
        txn(0, 1, 0, WORD,  5'd30, 64'hDEADBEEF, 0, 1, 64'h0,        "i0 wr30",    acc_x);
        txn(0, 0, 1, HALF,  5'd30, 64'h0,        1, 0, 64'h0,        "i0 rd30",    acc_x);
        txn(0, 1, 0, BYTE,  5'd4,  64'h100,      0, 1, 64'h0,        "i0 wrbig",   acc_x);
        txn(0, 0, 1, WORD,  5'd4,  64'h0,        1, 0, 64'hA1B2C3D4, "i0 rd4b",    acc_x);
        txn(0, 1, 0, DWORD, 5'd0,  64'h5,        0, 1, 64'h0,        "i0 wrdw",    acc_x);
        txn(0, 0, 1, DWORD, 5'd0,  64'h0,        1, 1, 64'h0,        "i0 rddw",    acc_x);
        txn(0, 1, 1, WORD,  5'd4,  64'h0,        1, 1, 64'h0,        "i0 wr+rd",   acc_x);
        txn(0, 0, 1, BYTE,  5'd5,  64'h0,        1, 0, 64'hC3,       "i0 rdb5",    acc_x);
        txn(0, 0, 1, HALF,  5'd6,  64'h0,        1, 0, 64'hA1B2,     "i0 rdh6",    acc_x);
        idle(0);
        repeat (3) @(negedge clk);
        check("i0 rd_data hold", rd_v[0], 64'hA1B2);
        we_v[0] = 1'b1; addr_v[0] = 5'd4; size_v[0] = WORD; wd_v[0] = 64'hFF;
        repeat (3) @(negedge clk);
        en_v[0] = 1'b1; we_v[0] = 1'b0; re_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("i0 no-op done", 64'(done_v[0]), 64'd1);
        @(posedge clk); #1;
        txn(0, 0, 1, WORD,  5'd4,  64'h0,        1, 0, 64'hA1B2C3D4, "i0 rd4c",    acc_x);
        idle(0);

        // 32b, 3 wait states, wrap-around
        txn(1, 1, 0, WORD, 5'd4, 64'hA1B2C3D4, 0, 0, 64'h0, "i1 wr4", acc_x);
        idle(1);
        txn(1, 0, 1, BYTE, 5'd5, 64'h0, 1, 0, 64'hC3, "i1 rdb5", acc_x);
        idle(1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("i1 done low %0d", i), 64'(done_v[1]), 64'd0);
        end
        @(negedge clk);
        check("i1 done back", 64'(done_v[1]), 64'd1);
        txn(1, 1, 0, WORD, 5'd30, 64'h11223344, 0, 0, 64'h0,        "i1 wr30",  acc_x);
        txn(1, 0, 1, BYTE, 5'd30, 64'h0,        1, 0, 64'h44,       "i1 rd30",  acc_x);
        txn(1, 0, 1, BYTE, 5'd31, 64'h0,        1, 0, 64'h33,       "i1 rd31",  acc_x);
        txn(1, 0, 1, BYTE, 5'd0,  64'h0,        1, 0, 64'h22,       "i1 rd0",   acc_x);
        txn(1, 0, 1, BYTE, 5'd1,  64'h0,        1, 0, 64'h11,       "i1 rd1",   acc_x);
        txn(1, 0, 1, WORD, 5'd30, 64'h0,        1, 0, 64'h11223344, "i1 rdw30", acc_x);
        idle(1);

        // 64b, 2 wait states: back-to-back doubleword, then reset abort
        txn(2, 1, 0, DWORD, 5'd8, 64'h0123456789ABCDEF, 0, 0, 64'h0,                "i2 wr8", acc_w);
        txn(2, 0, 1, DWORD, 5'd8, 64'h0,                1, 0, 64'h0123456789ABCDEF, "i2 rd8", acc_r);
        check("i2 back-to-back accept", 64'(acc_r), 64'(acc_w + 3));
        txn(2, 1, 0, DWORD, 5'd16, 64'hCAFEF00D12345678, 0, 0, 64'h0, "i2 wr16", acc_x);
        idle(2);
        @(negedge clk);
        check("i2 in access", 64'(done_v[2]), 64'd0);
        rst_n_v[2] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("i2 abort rd_valid", 64'(rdv_v[2]), 64'd0);
        check("i2 abort check", 64'(chk_v[2]), 64'd0);
        rst_n_v[2] = 1'b1;
        @(negedge clk);
        check("i2 done after reset", 64'(done_v[2]), 64'd1);
        @(posedge clk); #1;
        txn(2, 0, 1, DWORD, 5'd16, 64'h0, 1, 0, 64'h0, "i2 rd16", acc_x);
        idle(2);

        repeat (10) @(negedge clk);
        for (int k = 0; k < 3; k++)
            check($sformatf("inst%0d queue drained", k), 64'(exp_q[k].size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_hs.md
REG_FILE_HS -- requirements
Module: reg_file_hs

Interface
REQ-001 Parameter DATA_W, default 32, data bus width in bits; legal values 32 or 64.
REQ-002 Parameter DEPTH, default 32, storage depth in bytes; power of two, at least 8.
REQ-003 Parameter WAIT_STATES, default 0, access wait cycles per transaction; legal range 0..15.
REQ-004 Parameter WRAP_EN, default 0, selects boundary handling: 1 = address wraps modulo DEPTH, 0 = boundary crossing is an error.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 en  in  1  slave select.
REQ-008 addr  in  $clog2(DEPTH)  byte start address.
REQ-009 size  in  2  transfer size: 00 byte, 01 halfword, 10 word, 11 doubleword (doubleword legal only when DATA_W=64).
REQ-010 we  in  1  write request.
REQ-011 re  in  1  read request.
REQ-012 wd_data  in  DATA_W  write data, little-endian (lowest byte to addr).
REQ-013 rd_data  out  DATA_W  registered read data.
REQ-014 rd_valid  out  1  one-cycle pulse marking a completed read.
REQ-015 done  out  1  ready; high when a new request can be accepted.
REQ-016 check  out  1  error response, valid in the response cycle only.

Function
REQ-017 FSM states: IDLE, ACCESS, RESP; done SHALL be 1 in IDLE and RESP, and 0 in ACCESS.
REQ-018 A request SHALL be accepted on a rising edge where done=1, en=1 and (we|re)=1; addr, size, we, re and wd_data are captured at acceptance.
REQ-019 On acceptance: go to ACCESS with wait counter = WAIT_STATES-1 if WAIT_STATES>0, else go directly to RESP.
REQ-020 In ACCESS the counter SHALL decrement each cycle; at 0 the FSM moves to RESP, so the response cycle begins exactly WAIT_STATES+1 edges after acceptance.
REQ-021 The write commit and the rd_data capture SHALL both occur on the edge that enters RESP.
REQ-022 In RESP: rd_valid=1 for a read; check=1 if the captured request has an error; next state is IDLE, or a new acceptance if one is offered (back-to-back, no bubble).
REQ-023 An error SHALL be flagged for any of: we and re both set; size=11 when DATA_W=32; (addr + bytes - 1) >= DEPTH when WRAP_EN=0; any wd_data bit above the transfer size set on a write.
REQ-024 An erroring write SHALL modify no byte; an erroring read SHALL return rd_data=0 and still pulse rd_valid.
REQ-025 With WRAP_EN=1, byte i of a transfer SHALL address (addr+i) mod DEPTH, and no boundary error is raised.
REQ-026 Read data SHALL be zero-extended above the transfer size; rd_data holds its value until the next read response.
REQ-027 A read accepted in the RESP cycle of a write to an overlapping address SHALL return the newly written data.
REQ-028 en=0, or we=re=0, in IDLE SHALL leave all state unchanged.

Reset
REQ-029 When rst_n=0: FSM to IDLE, counter 0, all storage bytes 0, rd_data 0, rd_valid 0, check 0, done 1.
REQ-030 Reset asserted mid-transaction SHALL abort the transaction with no commit and no response pulse.

Structure
REQ-031 Package reg_file_pkg SHALL hold the size_t enum (BYTE, HALF, WORD, DWORD), the state_t enum, and a function returning the byte count for a size.
REQ-032 Byte storage plus the lane write/read muxing SHALL live in sub-module reg_file_mem; reg_file_hs holds the FSM, counter, capture registers and error logic.

Verification
REQ-033 Defaults; write word 0xA1B2C3D4 at addr 4, then read word at addr 4 -> rd_data=0xA1B2C3D4, check=0, response one edge after acceptance.
REQ-034 WAIT_STATES=3; read byte at addr 5 after the REQ-033 write -> done low for 3 cycles, then rd_valid=1 with rd_data=0x000000C3.
REQ-035 WRAP_EN=0; write word at addr 30 -> check=1 in RESP and bytes 30/31 unchanged; WRAP_EN=1, same write of 0x11223344 -> bytes 30,31,0,1 = 44,33,22,11.
REQ-036 Byte write with wd_data=0x0000_0100 -> check=1, no byte modified; size=11 with DATA_W=32 -> check=1.
REQ-037 DATA_W=64; doubleword write 0x0123456789ABCDEF at addr 8, back-to-back doubleword read at addr 8 -> read returns 0x0123456789ABCDEF with no idle cycle between.
REQ-038 WAIT_STATES=2; pulse rst_n low during ACCESS of a write -> target bytes remain 0, rd_valid/check stay 0, done=1 after reset release.
